// File: rtl/spi_slave.sv
// spi_slave: mode-0 SPI target. Oversamples pad-level SCK/SS/MOSI in the system
// clock, shifts bytes MSB-first and exchanges them with the bus side over
// one-byte valid/ready streams. Pin-to-action latency is 3 clock cycles.
// Ports:
//   io_mainClk, io_asyncResetN             - system clock, async active-low reset
//   io_spi_sclk/ss/mosi, io_spi_miso       - SPI pads (CPOL=0, CPHA=0)
//   io_spi_misoEnable                      - SB_IO output enable, high while selected
//   io_rx_valid/payload/ready              - received-byte stream (1-deep output reg)
//   io_tx_valid/payload/ready              - transmit-byte stream (1-deep holding reg)
//   io_status_busy/overrun/underrun        - ACTIVE level, dropped-byte and idle-fill pulses
module spi_slave #(
  parameter logic [7:0] TX_IDLE = 8'hFF
) (
  input  logic       io_mainClk,
  input  logic       io_asyncResetN,
  input  logic       io_spi_sclk,
  input  logic       io_spi_ss,
  input  logic       io_spi_mosi,
  output logic       io_spi_miso,
  output logic       io_spi_misoEnable,
  output logic       io_rx_valid,
  output logic [7:0] io_rx_payload,
  input  logic       io_rx_ready,
  input  logic       io_tx_valid,
  input  logic [7:0] io_tx_payload,
  output logic       io_tx_ready,
  output logic       io_status_busy,
  output logic       io_status_overrun,
  output logic       io_status_underrun
);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t      state_q, state_d;

  // [0],[1] are the synchroniser stages, [2] holds the previous synced value
  // for edge detection. MOSI only needs to line up with the synced SCK.
  logic [2:0]  sck_q;
  logic [2:0]  ss_q;
  logic [1:0]  mosi_q;

  logic [2:0]  bitcnt;
  logic [6:0]  rx_shift;
  logic [6:0]  tx_rest;      // bits still to be driven after the current MISO bit
  logic [7:0]  hold_dat;
  logic        hold_full;

  logic        sck_rise, sck_fall, ss_fall, ss_rise, mosi_s;
  logic        start, stop, shift_in, shift_out, load, accept, byte_done;
  logic        underrun_d;
  logic [7:0]  next_tx;
  logic [7:0]  rx_byte;

  assign sck_rise = sck_q[1] & ~sck_q[2];
  assign sck_fall = ~sck_q[1] & sck_q[2];
  assign ss_fall  = ~ss_q[1] & ss_q[2];
  assign ss_rise  = ss_q[1] & ~ss_q[2];
  assign mosi_s   = mosi_q[1];

  always_ff @(posedge io_mainClk or negedge io_asyncResetN) begin
    if (!io_asyncResetN) begin
      sck_q  <= 3'b000;
      ss_q   <= 3'b111;
      mosi_q <= 2'b00;
    end else begin
      sck_q  <= {sck_q[1:0], io_spi_sclk};
      ss_q   <= {ss_q[1:0], io_spi_ss};
      mosi_q <= {mosi_q[0], io_spi_mosi};
    end
  end

  // State register
  always_ff @(posedge io_mainClk or negedge io_asyncResetN) begin
    if (!io_asyncResetN) state_q <= IDLE;
    else                 state_q <= state_d;
  end

  // Next state and per-cycle control. SS deassert masks any SCK edge seen in
  // the same cycle.
  always_comb begin
    state_d    = state_q;
    start      = 1'b0;
    stop       = 1'b0;
    shift_in   = 1'b0;
    shift_out  = 1'b0;
    case (state_q)
      IDLE: begin
        if (ss_fall) begin
          state_d = ACTIVE;
          start   = 1'b1;
        end
      end
      ACTIVE: begin
        if (ss_rise) begin
          state_d = IDLE;
          stop    = 1'b1;
        end else begin
          shift_in  = sck_rise;
          shift_out = sck_fall;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A load point pulls the next TX byte: the held byte, else a byte being
  // accepted this very cycle (bypassing the holding register), else TX_IDLE.
  always_comb begin
    load       = start | (shift_out & (bitcnt == 3'd0));
    accept     = io_tx_valid & ~hold_full;
    next_tx    = TX_IDLE;
    underrun_d = 1'b0;
    if (hold_full)   next_tx = hold_dat;
    else if (accept) next_tx = io_tx_payload;
    else             underrun_d = load;
    rx_byte    = {rx_shift, mosi_s};
    byte_done  = shift_in & (bitcnt == 3'd7);
  end

  // TX holding register
  always_ff @(posedge io_mainClk or negedge io_asyncResetN) begin
    if (!io_asyncResetN) begin
      hold_dat  <= 8'h00;
      hold_full <= 1'b0;
    end else if (load) begin
      hold_full <= 1'b0;
    end else if (accept) begin
      hold_dat  <= io_tx_payload;
      hold_full <= 1'b1;
    end
  end

  // Shifters, bit counter and MISO pad
  always_ff @(posedge io_mainClk or negedge io_asyncResetN) begin
    if (!io_asyncResetN) begin
      bitcnt            <= 3'd0;
      rx_shift          <= 7'd0;
      tx_rest           <= 7'd0;
      io_spi_miso       <= 1'b0;
      io_spi_misoEnable <= 1'b0;
    end else begin
      if (stop) begin
        bitcnt            <= 3'd0;
        rx_shift          <= 7'd0;
        io_spi_miso       <= 1'b0;
        io_spi_misoEnable <= 1'b0;
      end else begin
        if (start) begin
          bitcnt            <= 3'd0;
          io_spi_misoEnable <= 1'b1;
        end
        if (shift_in) begin
          bitcnt   <= bitcnt + 3'd1;
          rx_shift <= rx_byte[6:0];
        end
        if (load) begin
          io_spi_miso <= next_tx[7];
          tx_rest     <= next_tx[6:0];
        end else if (shift_out) begin
          io_spi_miso <= tx_rest[6];
          tx_rest     <= {tx_rest[5:0], 1'b0};
        end
      end
    end
  end

  // RX output register and status pulses
  always_ff @(posedge io_mainClk or negedge io_asyncResetN) begin
    if (!io_asyncResetN) begin
      io_rx_valid        <= 1'b0;
      io_rx_payload      <= 8'h00;
      io_status_overrun  <= 1'b0;
      io_status_underrun <= 1'b0;
    end else begin
      io_status_overrun  <= 1'b0;
      io_status_underrun <= underrun_d;
      if (byte_done) begin
        // Room if empty or being drained this cycle; otherwise the old byte wins.
        if (!io_rx_valid || io_rx_ready) begin
          io_rx_payload <= rx_byte;
          io_rx_valid   <= 1'b1;
        end else begin
          io_status_overrun <= 1'b1;
        end
      end else if (io_rx_valid && io_rx_ready) begin
        io_rx_valid <= 1'b0;
      end
    end
  end

  assign io_tx_ready    = ~hold_full;
  assign io_status_busy = (state_q == ACTIVE);

endmodule

// File: tb/tb_spi_slave.sv
// tb_spi_slave: directed bench for spi_slave. A table of single-byte transfers
// (preload, MOSI byte, expected MISO byte, expected RX byte, expected underruns)
// is replayed in a loop; overrun, abort, burst and reset get hand-written sequences.
`timescale 1ns/1ps
module tb_spi_slave;

  localparam int HALF = 8;   // SCK half period in clock cycles (SCK = clk/16)

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sclk = 1'b0;
  logic       ss = 1'b1;
  logic       mosi = 1'b0;
  logic       rx_ready = 1'b0;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_payload = 8'h00;

  logic       miso, miso_en, rx_valid, tx_ready, busy, overrun, underrun;
  logic [7:0] rx_payload;

  spi_slave #(.TX_IDLE(8'hFF)) dut (
    .io_mainClk        (clk),
    .io_asyncResetN    (rst_n),
    .io_spi_sclk       (sclk),
    .io_spi_ss         (ss),
    .io_spi_mosi       (mosi),
    .io_spi_miso       (miso),
    .io_spi_misoEnable (miso_en),
    .io_rx_valid       (rx_valid),
    .io_rx_payload     (rx_payload),
    .io_rx_ready       (rx_ready),
    .io_tx_valid       (tx_valid),
    .io_tx_payload     (tx_payload),
    .io_tx_ready       (tx_ready),
    .io_status_busy    (busy),
    .io_status_overrun (overrun),
    .io_status_underrun(underrun)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int ovr_cnt = 0;
  int und_cnt = 0;
  int rxv_cnt = 0;

  // Pulse counters, sampled on the falling edge
  always @(negedge clk) begin
    if (overrun)  ovr_cnt = ovr_cnt + 1;
    if (underrun) und_cnt = und_cnt + 1;
    if (rx_valid) rxv_cnt = rxv_cnt + 1;
  end

  typedef struct {
    logic       pre;
    logic [7:0] tx;
    logic [7:0] mo;
    logic [7:0] exp_mi;
    logic [7:0] exp_rx;
    int         exp_und;
  } vec_t;

  vec_t vt [5];

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Shift nbits MSB-first; SCK must be low on entry and is left high on exit.
  // v2/v4 capture rx_valid 2 and 4 cycles after the last rising edge.
  task automatic spi_xfer(input logic [7:0] b, input int nbits,
                          output logic [7:0] mi, output logic v2, output logic v4);
    logic [7:0] bb;
    bb = b;
    mi = 8'h00;
    v2 = 1'b0;
    v4 = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      if (i != 0) sclk = 1'b0;
      mosi = bb[3'(7 - i)];
      cyc(HALF);
      mi = {mi[6:0], miso};
      sclk = 1'b1;
      if (i == nbits - 1) begin
        cyc(2);
        v2 = rx_valid;
        cyc(2);
        v4 = rx_valid;
        cyc(HALF - 4);
      end else begin
        cyc(HALF);
      end
    end
  endtask

  task automatic ss_begin();
    ss = 1'b0;
    cyc(HALF);
  endtask

  task automatic ss_end();
    sclk = 1'b0;
    cyc(HALF);
    ss = 1'b1;
    cyc(HALF);
  endtask

  task automatic push_tx(input logic [7:0] b);
    int k;
    k = 0;
    tx_payload = b;
    tx_valid   = 1'b1;
    while (!tx_ready && k < 50) begin
      cyc(1);
      k++;
    end
    check("push_tx_ready", tx_ready, 1);
    cyc(1);
    tx_valid = 1'b0;
  endtask

  task automatic consume_rx();
    rx_ready = 1'b1;
    cyc(1);
    rx_ready = 1'b0;
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : main
    logic [7:0] mi, mi1, mi2, mi3;
    logic       v2, v4;
    int         und_snap;

    vt[0] = '{pre: 1'b1, tx: 8'hA5, mo: 8'h3C, exp_mi: 8'hA5, exp_rx: 8'h3C, exp_und: 0};
    vt[1] = '{pre: 1'b0, tx: 8'h00, mo: 8'h00, exp_mi: 8'hFF, exp_rx: 8'h00, exp_und: 1};
    vt[2] = '{pre: 1'b1, tx: 8'h5A, mo: 8'hFF, exp_mi: 8'h5A, exp_rx: 8'hFF, exp_und: 0};
    vt[3] = '{pre: 1'b1, tx: 8'h00, mo: 8'h81, exp_mi: 8'h00, exp_rx: 8'h81, exp_und: 0};
    vt[4] = '{pre: 1'b1, tx: 8'hC3, mo: 8'h96, exp_mi: 8'hC3, exp_rx: 8'h96, exp_und: 0};

    // Reset state
    cyc(3);
    check("rst_miso", miso, 0);
    check("rst_miso_en", miso_en, 0);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_rx_payload", rx_payload, 8'h00);
    check("rst_tx_ready", tx_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_overrun", overrun, 0);
    check("rst_underrun", underrun, 0);
    rst_n = 1'b1;
    cyc(4);

    // Table of single-byte transfers
    for (int v = 0; v < 5; v++) begin
      und_cnt = 0;
      if (vt[v].pre) begin
        push_tx(vt[v].tx);
        check("tbl_hold_full", tx_ready, 0);
      end
      ss = 1'b0;
      cyc(5);
      check("tbl_busy", busy, 1);
      check("tbl_miso_en", miso_en, 1);
      check("tbl_tx_ready_after_ss", tx_ready, 1);
      cyc(HALF - 5);
      spi_xfer(vt[v].mo, 8, mi, v2, v4);
      und_snap = und_cnt;
      check("tbl_miso_byte", mi, vt[v].exp_mi);
      check("tbl_rx_valid_early", v2, 0);
      check("tbl_rx_valid_late", v4, 1);
      check("tbl_rx_payload", rx_payload, vt[v].exp_rx);
      check("tbl_underrun_cnt", und_snap, vt[v].exp_und);
      ss_end();
      check("tbl_busy_end", busy, 0);
      check("tbl_miso_en_end", miso_en, 0);
      check("tbl_miso_end", miso, 0);
      consume_rx();
      check("tbl_rx_consumed", rx_valid, 0);
    end

    // Overrun: ready held low over two bytes, the second byte is dropped
    ovr_cnt = 0;
    ss_begin();
    spi_xfer(8'h11, 8, mi, v2, v4);
    sclk = 1'b0;
    spi_xfer(8'h22, 8, mi, v2, v4);
    ss_end();
    check("ovr_payload_kept", rx_payload, 8'h11);
    check("ovr_valid", rx_valid, 1);
    check("ovr_pulse_cnt", ovr_cnt, 1);
    consume_rx();

    // Ready raised around the second completion: new byte taken, no overrun
    ovr_cnt = 0;
    ss_begin();
    spi_xfer(8'h11, 8, mi, v2, v4);
    check("ovr2_first_valid", v4, 1);
    sclk = 1'b0;
    spi_xfer(8'h22, 7, mi, v2, v4);
    sclk = 1'b0;
    mosi = 1'b0;             // bit0 of 0x22
    cyc(HALF);
    sclk = 1'b1;
    cyc(2);
    rx_ready = 1'b1;
    cyc(4);
    rx_ready = 1'b0;
    cyc(HALF - 6);
    ss_end();
    check("ovr2_payload", rx_payload, 8'h22);
    check("ovr2_no_overrun", ovr_cnt, 0);

    // Abort after 5 bits, then a clean 0x81 transfer
    rxv_cnt = 0;
    ss_begin();
    spi_xfer(8'hF0, 5, mi, v2, v4);
    ss_end();
    check("abort_no_rx_valid", rxv_cnt, 0);
    check("abort_busy", busy, 0);
    ss_begin();
    spi_xfer(8'h81, 8, mi, v2, v4);
    check("abort_next_valid", v4, 1);
    check("abort_next_payload", rx_payload, 8'h81);
    ss_end();
    consume_rx();

    // Three-byte burst, next TX byte supplied during the preceding byte
    rx_ready = 1'b1;
    ovr_cnt  = 0;
    push_tx(8'h01);
    und_cnt = 0;
    ss_begin();
    push_tx(8'h02);
    spi_xfer(8'h10, 8, mi1, v2, v4);
    check("burst_rx0", rx_payload, 8'h10);
    sclk = 1'b0;
    cyc(4);
    push_tx(8'h03);
    spi_xfer(8'h20, 8, mi2, v2, v4);
    check("burst_rx1", rx_payload, 8'h20);
    sclk = 1'b0;
    spi_xfer(8'h30, 8, mi3, v2, v4);
    und_snap = und_cnt;
    check("burst_rx2", rx_payload, 8'h30);
    ss_end();
    rx_ready = 1'b0;
    check("burst_miso0", mi1, 8'h01);
    check("burst_miso1", mi2, 8'h02);
    check("burst_miso2", mi3, 8'h03);
    check("burst_no_underrun", und_snap, 0);
    check("burst_no_overrun", ovr_cnt, 0);
    check("burst_rx_drained", rx_valid, 0);

    // Reset mid-transfer, then SCK without SS is ignored
    push_tx(8'h77);
    ss_begin();
    spi_xfer(8'h55, 4, mi, v2, v4);
    rst_n = 1'b0;
    #1;
    check("mid_rst_miso", miso, 0);
    check("mid_rst_miso_en", miso_en, 0);
    check("mid_rst_rx_valid", rx_valid, 0);
    check("mid_rst_rx_payload", rx_payload, 8'h00);
    check("mid_rst_tx_ready", tx_ready, 1);
    check("mid_rst_busy", busy, 0);
    ss   = 1'b1;
    sclk = 1'b0;
    cyc(3);
    rst_n = 1'b1;
    cyc(2);
    rxv_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      sclk = 1'b1;
      cyc(HALF);
      sclk = 1'b0;
      cyc(HALF);
    end
    check("post_rst_busy", busy, 0);
    check("post_rst_miso_en", miso_en, 0);
    check("post_rst_no_rx", rxv_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
